booth_brick_sequencer: RTL and testbench

//  Time-multiplexes one 2x2 digit-multiplier brick to form a 2-, 4- or 8-bit signed/unsigned product.

---
 rtl/bb_seq_pkg.sv | 31 +++
 rtl/booth_brick_sequencer_if.sv | 27 ++
 rtl/bb_digit_mul.sv | 26 ++
 rtl/booth_brick_sequencer.sv | 155 +++++++++++++++
 tb/tb_booth_brick_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bb_seq_pkg.sv
// Shared types and constants for the booth brick sequencer lane.
// Digit geometry, precision encodings and the FSM state codes live here.
package bb_seq_pkg;

  localparam int DIGIT_W = 2;
  localparam int PP_W    = 5;

  localparam logic [1:0] PREC_2 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_8 = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } bb_state_e;

  // Digits per operand; the reserved encoding 2'b11 behaves as 8-bit.
  function automatic logic [2:0] prec_digits(input logic [1:0] p);
    case (p)
      PREC_2:  return 3'd1;
      PREC_4:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/booth_brick_sequencer_if.sv
// Request/response bundle between operand issue, the sequencer and writeback.
// slave = sequencer side, master = issuing/consuming side.
interface booth_brick_sequencer_if #(
  parameter int MAX_W = 8,
  parameter int RES_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       prec;
  logic             is_signed;
  logic [MAX_W-1:0] a;
  logic [MAX_W-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic             busy;

  modport slave (
    input  in_valid, prec, is_signed, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, prec, is_signed, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/bb_digit_mul.sv
// 2x2 digit multiplier brick: purely combinational, zero latency.
// No backpressure; each operand digit is unsigned 0..3 or, when flagged, signed -2..1.
module bb_digit_mul
  import bb_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0]      da,
  input  logic [DIGIT_W-1:0]      db,
  input  logic                    a_sgn,
  input  logic                    b_sgn,
  output logic signed [PP_W-1:0]  pp
);

  logic signed [DIGIT_W:0]  ea;
  logic signed [DIGIT_W:0]  eb;
  logic signed [2*DIGIT_W+1:0] prod;

  assign ea   = {a_sgn & da[DIGIT_W-1], da};
  assign eb   = {b_sgn & db[DIGIT_W-1], db};
  assign prod = (2*DIGIT_W+2)'(ea) * (2*DIGIT_W+2)'(eb);
  // Range is -6..9, so the top product bit is always a copy of bit PP_W-1.
  assign pp   = prod[PP_W-1:0];

  logic unused_prod_top;
  assign unused_prod_top = prod[2*DIGIT_W+1];

endmodule

// File: rtl/booth_brick_sequencer.sv
// Sequences one 2x2 digit brick over D*D digit pairs to build a 2/4/8-bit product.
// Latency D*D+1 edges from accept to out_valid (1 edge with BB_SEQ_ZERO_SKIP_EN on a zero operand).
// One operation in flight: in_ready low in RUN/DONE; result held while out_ready is low.
module booth_brick_sequencer
  import bb_seq_pkg::*;
#(
  parameter int MAX_W = 8,
  parameter int RES_W = 2*MAX_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  booth_brick_sequencer_if.slave    bus
);

  localparam int CNT_W = (MAX_W > 4) ? $clog2(MAX_W/2) : 1;
  localparam int ACC_W = RES_W + 1;

  logic [1:0]              state;
  logic [MAX_W-1:0]        a_q;
  logic [MAX_W-1:0]        b_q;
  logic [1:0]              prec_q;
  logic                    sgn_q;
  logic [CNT_W-1:0]        i_q;
  logic [CNT_W-1:0]        j_q;
  logic [CNT_W-1:0]        last_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [RES_W-1:0]        res_q;
  logic                    ovld_q;

  // Request side: mask off bits above the selected precision.
  logic [2:0]       d_in;
  logic [MAX_W-1:0] mask_in;
  logic [MAX_W-1:0] a_m;
  logic [MAX_W-1:0] b_m;
  logic             skip;

  always_comb begin
    mask_in = '0;
    d_in    = prec_digits(bus.prec);
    for (int k = 0; k < MAX_W; k++) begin
      mask_in[k] = (k < 2*int'(d_in));
    end
  end

  assign a_m = bus.a & mask_in;
  assign b_m = bus.b & mask_in;

`ifdef BB_SEQ_ZERO_SKIP_EN
  assign skip = (a_m == '0) || (b_m == '0);
`else
  assign skip = 1'b0;
`endif

  // Digit datapath: one shared brick, top digit signed for signed operands.
  logic [DIGIT_W-1:0]      da;
  logic [DIGIT_W-1:0]      db;
  logic signed [PP_W-1:0]  pp;
  logic signed [ACC_W-1:0] pp_ext;
  logic [CNT_W+1:0]        sh;

  assign da     = a_q[{i_q, 1'b0} +: DIGIT_W];
  assign db     = b_q[{j_q, 1'b0} +: DIGIT_W];
  assign pp_ext = ACC_W'(pp);
  assign sh     = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};

  bb_digit_mul u_mul (
    .da    (da),
    .db    (db),
    .a_sgn (sgn_q && (i_q == last_q)),
    .b_sgn (sgn_q && (j_q == last_q)),
    .pp    (pp)
  );

  // Result formatting: keep 4*D product bits, then sign- or zero-extend.
  logic [2:0]       d_run;
  logic [4:0]       msb_idx;
  logic             ext_bit;
  logic [RES_W-1:0] res_fmt;

  always_comb begin
    res_fmt = '0;
    d_run   = prec_digits(prec_q);
    msb_idx = {d_run, 2'b00} - 5'd1;
    ext_bit = sgn_q & acc_q[msb_idx];
    for (int k = 0; k < RES_W; k++) begin
      res_fmt[k] = (k < 4*int'(d_run)) ? acc_q[k] : ext_bit;
    end
  end

  logic unused_acc_top;
  assign unused_acc_top = acc_q[RES_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      prec_q <= PREC_2;
      sgn_q  <= 1'b0;
      i_q    <= '0;
      j_q    <= '0;
      last_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      ovld_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q    <= a_m;
            b_q    <= b_m;
            prec_q <= bus.prec;
            sgn_q  <= bus.is_signed;
            last_q <= CNT_W'(d_in - 3'd1);
            i_q    <= '0;
            j_q    <= '0;
            acc_q  <= '0;
            state  <= skip ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_q + (pp_ext << sh);
          if (j_q == last_q) begin
            j_q <= '0;
            if (i_q == last_q) begin
              state <= ST_DONE;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        ST_DONE: begin
          // First DONE cycle registers the formatted result; then wait for the sink.
          if (!ovld_q) begin
            ovld_q <= 1'b1;
            res_q  <= res_fmt;
          end else if (bus.out_ready) begin
            ovld_q <= 1'b0;
            res_q  <= '0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = ovld_q;
  assign bus.result    = res_q;

endmodule

// File: tb/tb_booth_brick_sequencer.sv
// Bench for booth_brick_sequencer: vector table, random ops against a reference
// multiply, and hand-written backpressure / mid-run reset sequences.
module tb_booth_brick_sequencer;

  logic clk;
  logic rst_n;

  booth_brick_sequencer_if #(.MAX_W(8), .RES_W(16)) bus ();

  booth_brick_sequencer #(.MAX_W(8), .RES_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  p;
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] p);
    return (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [1:0] p, input logic s,
                                          input logic [7:0] a, input logic [7:0] b);
    int w, av, bv, prod;
    w  = width_of(p);
    av = int'(a) & ((1 << w) - 1);
    bv = int'(b) & ((1 << w) - 1);
    if (s && av >= (1 << (w - 1))) av -= (1 << w);
    if (s && bv >= (1 << (w - 1))) bv -= (1 << w);
    prod = av * bv;
    return 16'(prod);
  endfunction

  function automatic int exp_lat(input logic [1:0] p, input logic [7:0] a, input logic [7:0] b);
    int w, d, am, bm;
    w  = width_of(p);
    d  = w / 2;
    am = int'(a) & ((1 << w) - 1);
    bm = int'(b) & ((1 << w) - 1);
`ifdef BB_SEQ_ZERO_SKIP_EN
    if (am == 0 || bm == 0) return 1;
`else
    if (am == 0 && bm == 0) return d * d + 1;
`endif
    return d * d + 1;
  endfunction

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drive_req(input logic [1:0] p, input logic s, input logic [7:0] av, input logic [7:0] bv);
    bus.prec      = p;
    bus.is_signed = s;
    bus.a         = av;
    bus.b         = bv;
    bus.in_valid  = 1'b1;
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string name, input logic [1:0] p, input logic s,
                        input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expr);
    exp_t e;
    int   n;
    drive_req(p, s, av, bv);
    bus.out_ready = 1'b1;
    check({name, " accept_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    e.res = expr;
    e.lat = exp_lat(p, av, bv);
    sb.push_back(e);
    wait_out(n);
    e = sb.pop_front();
    check({name, " latency"}, 32'(n), 32'(e.lat));
    check({name, " result"}, 32'(bus.result), 32'(e.res));
    @(posedge clk);
    #1;
    check({name, " release"}, 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'(3'b010));
  endtask

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    int   hi;
    logic [1:0]  rp;
    logic        rs;
    logic [7:0]  ra, rb;

    vecs[0]  = '{2'b10, 1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{2'b01, 1'b0, 8'h3F, 8'h0F, 16'h00E1};
    vecs[2]  = '{2'b00, 1'b1, 8'h02, 8'h01, 16'hFFFE};
    vecs[3]  = '{2'b00, 1'b0, 8'h02, 8'h01, 16'h0002};
    vecs[4]  = '{2'b10, 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[5]  = '{2'b10, 1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[6]  = '{2'b10, 1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[7]  = '{2'b01, 1'b1, 8'h08, 8'h07, 16'hFFC8};
    vecs[8]  = '{2'b11, 1'b0, 8'h10, 8'h10, 16'h0100};
    vecs[9]  = '{2'b00, 1'b1, 8'h02, 8'h02, 16'h0004};
    vecs[10] = '{2'b00, 1'b0, 8'hFF, 8'h03, 16'h0009};
    vecs[11] = '{2'b00, 1'b1, 8'h03, 8'h03, 16'h0001};
    vecs[12] = '{2'b10, 1'b0, 8'h00, 8'h55, 16'h0000};
    vecs[13] = '{2'b01, 1'b1, 8'hF0, 8'h05, 16'h0000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.prec      = 2'b00;
    bus.is_signed = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'(3'b100));
    check("reset result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 14; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].p, vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].exp);
    end

    for (int r = 0; r < 12; r++) begin
      rp = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op($sformatf("rand%0d", r), rp, rs, ra, rb, ref_mul(rp, rs, ra, rb));
    end

    // Backpressure: result held, new requests ignored while DONE.
    drive_req(2'b10, 1'b0, 8'h12, 8'h34);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    e.res = ref_mul(2'b10, 1'b0, 8'h12, 8'h34);
    e.lat = exp_lat(2'b10, 8'h12, 8'h34);
    sb.push_back(e);
    wait_out(n);
    e = sb.pop_front();
    check("bp latency", 32'(n), 32'(e.lat));
    for (int c = 0; c < 5; c++) begin
      drive_req(2'b00, 1'b0, 8'hFF, 8'hFF);
      bus.in_valid = c[0];
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d", c),
            32'({bus.out_valid, bus.in_ready, bus.result}), {15'd0, 1'b1, 1'b0, e.res});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'(3'b010));
    repeat (3) @(posedge clk);
    #1;
    check("bp no queued op", 32'({bus.busy, bus.out_valid}), 32'd0);

    // Reset in the third RUN cycle of an 8-bit op.
    drive_req(2'b10, 1'b1, 8'h80, 8'h80);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'(3'b100));
    check("midrst result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) hi++;
    end
    check("midrst no stale output", 32'(hi), 32'd0);
    run_op("after reset", 2'b10, 1'b1, 8'h7F, 8'h80, 16'hC080);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
